ram_pattern_checker: RTL and testbench

// - Pattern writer/reader-checker for true_dual_port_ram_* instances: fills the RAM through port 1, reads it back through port 2.
// - Compares read data against the expected pattern and counts mismatches.
// - Sits beside the RAM in memory test apps; its status drives LEDs/debug.

---
 rtl/ram_pattern_checker_if.sv | 27 ++
 rtl/ram_pattern_checker.sv | 159 +++++++++++++++
 tb/tb_ram_pattern_checker.sv | 318 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ram_pattern_checker_if.sv
// RAM-side bus between the pattern checker (master) and a true dual-port RAM (slave).
// Port 1 carries the pattern writes and port 2 carries the read-back.
interface ram_pattern_checker_if #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 10
);
    logic                  enable1;
    logic                  write1;
    logic [ADDR_WIDTH-1:0] addr1;
    logic [DATA_WIDTH-1:0] idata1;
    logic                  enable2;
    logic                  write2;
    logic [ADDR_WIDTH-1:0] addr2;
    logic [DATA_WIDTH-1:0] odata2;

    modport master (
        output enable1, write1, addr1, idata1,
        output enable2, write2, addr2,
        input  odata2
    );

    modport slave (
        input  enable1, write1, addr1, idata1,
        input  enable2, write2, addr2,
        output odata2
    );
endinterface

// File: rtl/ram_pattern_checker.sv
// Writes an address^seed pattern through RAM port 1, reads it back through port 2 and counts mismatches.
// Optional STOP_ON_ERROR_EN: the first mismatch ends the pass early and keeps the seed for a retry.
module ram_pattern_checker #(
    parameter int DATA_WIDTH   = 8,
    parameter int ADDR_WIDTH   = 10,
    parameter int READ_LATENCY = 1
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  start,
    ram_pattern_checker_if.master ram,
    output logic                  busy,
    output logic                  done,
    output logic                  error,
    output logic [15:0]           error_count,
    output logic [ADDR_WIDTH-1:0] first_addr,
    output logic [DATA_WIDTH-1:0] seed
);

    localparam int TAIL = READ_LATENCY - 1;

    typedef enum logic [2:0] {IDLE, WRITE, READ, DRAIN, DONE} state_t;

    state_t                state;
    state_t                state_next;
    logic [ADDR_WIDTH-1:0] addr_cnt;
    logic [2:0]            drain_cnt;
    logic                  mismatch;

    logic                  vld_p  [READ_LATENCY];
    logic [ADDR_WIDTH-1:0] addr_p [READ_LATENCY];
    logic [DATA_WIDTH-1:0] exp_p  [READ_LATENCY];

    function automatic logic [DATA_WIDTH-1:0] pattern(input logic [ADDR_WIDTH-1:0] a,
                                                      input logic [DATA_WIDTH-1:0] s);
        return DATA_WIDTH'(a) ^ s;
    endfunction

    function automatic logic [15:0] sat_inc(input logic [15:0] c);
        return (c == 16'hFFFF) ? c : c + 16'd1;
    endfunction

    // Compare stage: the pipeline tail lines up with the RAM read data.
    assign mismatch = ((state == READ) || (state == DRAIN)) && vld_p[TAIL] &&
                      (ram.odata2 != exp_p[TAIL]);

    always_ff @(posedge clock) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next  = state;
        ram.enable1 = 1'b0;
        ram.write1  = 1'b0;
        ram.addr1   = '0;
        ram.idata1  = '0;
        ram.enable2 = 1'b0;
        ram.write2  = 1'b0;
        ram.addr2   = '0;
        busy        = 1'b0;
        done        = 1'b0;
        case (state)
            IDLE: begin
                if (start) state_next = WRITE;
            end
            WRITE: begin
                busy        = 1'b1;
                ram.enable1 = 1'b1;
                ram.write1  = 1'b1;
                ram.addr1   = addr_cnt;
                ram.idata1  = pattern(addr_cnt, seed);
                if (addr_cnt == '1) state_next = READ;
            end
            READ: begin
                busy        = 1'b1;
                ram.enable2 = 1'b1;
                ram.addr2   = addr_cnt;
                if (addr_cnt == '1) state_next = DRAIN;
            end
            DRAIN: begin
                busy = 1'b1;
                if (drain_cnt == 3'(READ_LATENCY - 1)) state_next = DONE;
            end
            DONE: begin
                done       = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
`ifdef STOP_ON_ERROR_EN
        if (mismatch) state_next = DONE;
`endif
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            addr_cnt    <= '0;
            drain_cnt   <= '0;
            error       <= 1'b0;
            error_count <= '0;
            first_addr  <= '0;
            seed        <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        addr_cnt    <= '0;
                        error_count <= '0;
                        first_addr  <= '0;
                    end
                end
                WRITE: addr_cnt <= addr_cnt + 1'b1;
                READ: begin
                    addr_cnt  <= addr_cnt + 1'b1;
                    drain_cnt <= '0;
                end
                DRAIN: drain_cnt <= drain_cnt + 3'd1;
                DONE: begin
`ifdef STOP_ON_ERROR_EN
                    // A failed pass keeps its seed so the same pattern can be retried.
                    if (error_count == '0) seed <= seed + DATA_WIDTH'(1);
`else
                    seed <= seed + DATA_WIDTH'(1);
`endif
                end
                default: ;
            endcase
            if (mismatch) begin
                error_count <= sat_inc(error_count);
                if (error_count == '0) first_addr <= addr_p[TAIL];
                error <= 1'b1;
            end
        end
    end

    // Read pipeline: valid bits are control, cleared on DONE so an abandoned pass leaves nothing behind.
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < READ_LATENCY; i++) vld_p[i] <= 1'b0;
        end else begin
            vld_p[0] <= (state == READ);
            for (int i = 1; i < READ_LATENCY; i++) vld_p[i] <= vld_p[i-1];
            if (state == DONE) begin
                for (int i = 0; i < READ_LATENCY; i++) vld_p[i] <= 1'b0;
            end
        end
    end

    always_ff @(posedge clock) begin
        addr_p[0] <= addr_cnt;
        exp_p[0]  <= pattern(addr_cnt, seed);
        for (int i = 1; i < READ_LATENCY; i++) begin
            addr_p[i] <= addr_p[i-1];
            exp_p[i]  <= exp_p[i-1];
        end
    end

endmodule

// File: tb/tb_ram_pattern_checker.sv
// Bench for ram_pattern_checker: two instances (read latency 1 and 3) beside behavioural RAMs,
// checked every cycle against a pass-timeline model plus hand-computed literal expectations.
module tb_ram_pattern_checker;

    localparam int N = 16;
`ifdef STOP_ON_ERROR_EN
    localparam bit STOP = 1'b1;
`else
    localparam bit STOP = 1'b0;
`endif

    logic        clk;
    logic [1:0]  rst_v;
    logic [1:0]  start_v;
    logic [1:0]  busy_v, done_v, error_v;
    logic [15:0] ec_v   [2];
    logic [3:0]  fa_v   [2];
    logic [7:0]  seed_v [2];

    int tests = 0;
    int fails = 0;
    bit chk_on = 1'b0;

    ram_pattern_checker_if #(.DATA_WIDTH(8), .ADDR_WIDTH(4)) bus0 ();
    ram_pattern_checker_if #(.DATA_WIDTH(8), .ADDR_WIDTH(4)) bus1 ();

    ram_pattern_checker #(.DATA_WIDTH(8), .ADDR_WIDTH(4), .READ_LATENCY(1)) u_dut0 (
        .clock(clk), .reset(rst_v[0]), .start(start_v[0]), .ram(bus0),
        .busy(busy_v[0]), .done(done_v[0]), .error(error_v[0]),
        .error_count(ec_v[0]), .first_addr(fa_v[0]), .seed(seed_v[0]));

    ram_pattern_checker #(.DATA_WIDTH(8), .ADDR_WIDTH(4), .READ_LATENCY(3)) u_dut1 (
        .clock(clk), .reset(rst_v[1]), .start(start_v[1]), .ram(bus1),
        .busy(busy_v[1]), .done(done_v[1]), .error(error_v[1]),
        .error_count(ec_v[1]), .first_addr(fa_v[1]), .seed(seed_v[1]));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Behavioural RAMs with read latency 1 (dut0) and 3 (dut1) and injectable read corruption.
    int         corrupt_addr [2];
    bit         invert_all   [2];
    logic [7:0] mem [2][N];
    logic [7:0] rdq [2][3];

    function automatic logic [7:0] rd_value(input int d, input logic [3:0] a);
        logic [7:0] v;
        v = mem[d][a];
        if (invert_all[d])             v = ~v;
        else if (corrupt_addr[d] == a) v = v ^ 8'h80;
        return v;
    endfunction

    always @(posedge clk) begin
        if (bus0.enable1 && bus0.write1) mem[0][bus0.addr1] <= bus0.idata1;
        if (bus1.enable1 && bus1.write1) mem[1][bus1.addr1] <= bus1.idata1;
        if (bus0.enable2) rdq[0][0] <= rd_value(0, bus0.addr2);
        if (bus1.enable2) rdq[1][0] <= rd_value(1, bus1.addr2);
        rdq[1][1] <= rdq[1][0];
        rdq[1][2] <= rdq[1][1];
    end

    assign bus0.odata2 = rdq[0][0];
    assign bus1.odata2 = rdq[1][2];

    // Pass-timeline model: offset k counts cycles from the accepted start cycle (k=0).
    // Writes at k=1..N, reads at k=N+1..2N, read of word j is judged at k=N+1+j+RL.
    bit         in_pass [2];
    int         k_m     [2];
    int         plen    [2];
    logic [7:0] m_seed  [2];
    bit         m_err   [2];
    logic [15:0] m_cnt  [2];
    logic [3:0] m_first [2];

    function automatic int rl_of(input int d);
        return (d == 0) ? 1 : 3;
    endfunction

    function automatic bit is_bad(input int d, input int j);
        return invert_all[d] || (corrupt_addr[d] == j);
    endfunction

    function automatic int pass_len(input int d);
        if (STOP) begin
            for (int j = 0; j < N; j++) if (is_bad(d, j)) return N + 2 + j + rl_of(d);
        end
        return 2 * N + rl_of(d) + 1;
    endfunction

    function automatic bit cmp_bad(input int d, input int k);
        int j;
        j = k - N - 1 - rl_of(d);
        return (j >= 0) && (j < N) && is_bad(d, j);
    endfunction

    always @(posedge clk) begin
        for (int d = 0; d < 2; d++) begin
            if (rst_v[d]) begin
                in_pass[d] <= 1'b0;
                k_m[d]     <= 0;
                plen[d]    <= 0;
                m_seed[d]  <= 8'd0;
                m_err[d]   <= 1'b0;
                m_cnt[d]   <= 16'd0;
                m_first[d] <= 4'd0;
            end else if (!in_pass[d]) begin
                if (start_v[d]) begin
                    in_pass[d] <= 1'b1;
                    k_m[d]     <= 1;
                    plen[d]    <= pass_len(d);
                    m_cnt[d]   <= 16'd0;
                    m_first[d] <= 4'd0;
                end
            end else begin
                k_m[d] <= k_m[d] + 1;
                if (k_m[d] < plen[d] && cmp_bad(d, k_m[d])) begin
                    if (m_cnt[d] != 16'hFFFF) m_cnt[d] <= m_cnt[d] + 16'd1;
                    if (m_cnt[d] == 16'd0) m_first[d] <= 4'(k_m[d] - N - 1 - rl_of(d));
                    m_err[d] <= 1'b1;
                end
                if (k_m[d] == plen[d]) begin
                    in_pass[d] <= 1'b0;
                    if (!STOP || m_cnt[d] == 16'd0) m_seed[d] <= m_seed[d] + 8'd1;
                end
            end
        end
    end

    task automatic chk(input string name, input longint act, input longint req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
        end
    endtask

    task automatic check_cycle(input int d, input logic e1, input logic w1, input logic [3:0] a1,
                               input logic [7:0] i1, input logic e2, input logic w2,
                               input logic [3:0] a2, input logic bsy, input logic dn,
                               input logic er, input logic [15:0] ec, input logic [3:0] fa,
                               input logic [7:0] sd);
        bit xe1, xe2;
        int kk;
        kk  = k_m[d];
        xe1 = in_pass[d] && kk >= 1 && kk <= N;
        xe2 = in_pass[d] && kk > N && kk <= 2 * N && kk < plen[d];
        chk($sformatf("d%0d.enable1", d), e1, xe1);
        chk($sformatf("d%0d.write1", d), w1, xe1);
        chk($sformatf("d%0d.addr1", d), a1, xe1 ? kk - 1 : 0);
        chk($sformatf("d%0d.idata1", d), i1, xe1 ? ((kk - 1) ^ m_seed[d]) : 0);
        chk($sformatf("d%0d.enable2", d), e2, xe2);
        chk($sformatf("d%0d.write2", d), w2, 0);
        chk($sformatf("d%0d.addr2", d), a2, xe2 ? kk - N - 1 : 0);
        chk($sformatf("d%0d.busy", d), bsy, in_pass[d] && kk < plen[d]);
        chk($sformatf("d%0d.done", d), dn, in_pass[d] && kk == plen[d]);
        chk($sformatf("d%0d.error", d), er, m_err[d]);
        chk($sformatf("d%0d.error_count", d), ec, m_cnt[d]);
        chk($sformatf("d%0d.first_addr", d), fa, m_first[d]);
        chk($sformatf("d%0d.seed", d), sd, m_seed[d]);
    endtask

    always @(negedge clk) begin
        if (chk_on) begin
            check_cycle(0, bus0.enable1, bus0.write1, bus0.addr1, bus0.idata1, bus0.enable2,
                        bus0.write2, bus0.addr2, busy_v[0], done_v[0], error_v[0], ec_v[0],
                        fa_v[0], seed_v[0]);
            check_cycle(1, bus1.enable1, bus1.write1, bus1.addr1, bus1.idata1, bus1.enable2,
                        bus1.write2, bus1.addr2, busy_v[1], done_v[1], error_v[1], ec_v[1],
                        fa_v[1], seed_v[1]);
        end
    end

    logic [7:0] cap [4];

    // Pulse start for one cycle and return the cycle (start cycle = 0) at which done shows.
    task automatic run_pass(input int d, input int exp_cycles, input string nm);
        int n;
        bit seen;
        @(posedge clk);
        #1 start_v[d] = 1'b1;
        @(negedge clk);
        @(posedge clk);
        #1 start_v[d] = 1'b0;
        n = 0;
        seen = 1'b0;
        while (!seen && n < 200) begin
            @(negedge clk);
            n++;
            if (d == 0 && n <= 4) cap[n-1] = bus0.idata1;
            if (done_v[d]) seen = 1'b1;
        end
        chk({nm, ".done_cycle"}, seen ? n : -1, exp_cycles);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int ndone;
        bit seen;
        rst_v           = 2'b11;
        start_v         = 2'b00;
        corrupt_addr[0] = -1;
        corrupt_addr[1] = -1;
        invert_all[0]   = 1'b0;
        invert_all[1]   = 1'b0;
        @(posedge clk);
        #1 chk_on = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst_v = 2'b00;
        @(negedge clk);
        chk("rst.busy", busy_v[0], 0);
        chk("rst.error_count", ec_v[0], 0);
        chk("rst.seed", seed_v[0], 0);
        chk("rst.enable1", bus0.enable1, 0);

        // First pass: idata1 = 0x00..0x0F, done at cycle 34.
        run_pass(0, 34, "pass1");
        chk("pass1.idata1_w1", cap[1], 8'h01);
        chk("pass1.idata1_w3", cap[3], 8'h03);
        @(negedge clk);
        chk("pass1.error_count", ec_v[0], 0);
        chk("pass1.error", error_v[0], 0);
        chk("pass1.seed", seed_v[0], 1);

        // Second pass: seed 1 gives 0x01,0x00,0x03,0x02...
        run_pass(0, 34, "pass2");
        chk("pass2.idata1_w0", cap[0], 8'h01);
        chk("pass2.idata1_w1", cap[1], 8'h00);
        chk("pass2.idata1_w2", cap[2], 8'h03);
        chk("pass2.idata1_w3", cap[3], 8'h02);
        @(negedge clk);
        chk("pass2.error_count", ec_v[0], 0);
        chk("pass2.seed", seed_v[0], 2);

        // Word 5 corrupted on read.
        corrupt_addr[0] = 5;
        run_pass(0, STOP ? 24 : 34, "corrupt");
        @(negedge clk);
        chk("corrupt.error_count", ec_v[0], 1);
        chk("corrupt.first_addr", fa_v[0], 5);
        chk("corrupt.error", error_v[0], 1);
        chk("corrupt.seed", seed_v[0], STOP ? 2 : 3);
        corrupt_addr[0] = -1;

        // start held high for 100 cycles: one pass per IDLE visit, period 35 cycles.
        @(posedge clk);
        #1 start_v[0] = 1'b1;
        ndone = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (done_v[0]) ndone++;
        end
        @(posedge clk);
        #1 start_v[0] = 1'b0;
        chk("hold.done_pulses", ndone, 2);
        n = 0;
        seen = 1'b0;
        while (!seen && n < 100) begin
            @(negedge clk);
            n++;
            if (done_v[0]) seen = 1'b1;
        end
        chk("hold.last_done", seen, 1);

        // Reset during READ: outputs clear next cycle, no done pulse afterwards.
        @(posedge clk);
        #1 start_v[0] = 1'b1;
        @(posedge clk);
        #1 start_v[0] = 1'b0;
        n = 0;
        while (!(bus0.enable2 && bus0.addr2 == 4'd8) && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("rstread.reached_read", bus0.enable2, 1);
        @(posedge clk);
        #1 rst_v[0] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("rstread.busy", busy_v[0], 0);
        chk("rstread.done", done_v[0], 0);
        chk("rstread.error", error_v[0], 0);
        chk("rstread.error_count", ec_v[0], 0);
        chk("rstread.seed", seed_v[0], 0);
        chk("rstread.enable2", bus0.enable2, 0);
        chk("rstread.addr2", bus0.addr2, 0);
        @(posedge clk);
        #1 rst_v[0] = 1'b0;
        ndone = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (done_v[0]) ndone++;
        end
        chk("rstread.no_done", ndone, 0);

        // Read latency 3, every read inverted.
        invert_all[1] = 1'b1;
        run_pass(1, STOP ? 21 : 36, "rl3inv");
        @(negedge clk);
        chk("rl3inv.error_count", ec_v[1], STOP ? 1 : 16);
        chk("rl3inv.first_addr", fa_v[1], 0);
        chk("rl3inv.error", error_v[1], 1);
        chk("rl3inv.seed", seed_v[1], STOP ? 0 : 1);

        repeat (3) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
